// File: rtl/conv_mac_engine.sv
// Windowed signed MAC behind a rotating weight shifter: one product per accepted
// pixel, KERNEL_SIZE products per window, then one rounded/saturated result.
module conv_mac_engine #(
  parameter int DATA_WIDTH  = 8,
  parameter int KERNEL_SIZE = 9,
  parameter int ACC_WIDTH   = 20,
  parameter int OUT_WIDTH   = 8,
  parameter int OUT_SHIFT   = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  output logic                         busy,
  input  logic                         pix_valid,
  output logic                         pix_ready,
  input  logic signed [DATA_WIDTH-1:0] pix_data,
  input  logic signed [DATA_WIDTH-1:0] weight_in,
  output logic                         shift_en,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic signed [OUT_WIDTH-1:0]  res_data,
  output logic                         res_sat
);

  localparam int CNT_W  = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int RW     = ACC_WIDTH + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KERNEL_SIZE - 1);
  localparam logic signed [RW-1:0] R_MAX = RW'(2 ** (OUT_WIDTH - 1) - 1);
  localparam logic signed [RW-1:0] R_MIN = RW'(-(2 ** (OUT_WIDTH - 1)));

  typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

  typedef struct packed {
    logic                        sat;
    logic signed [OUT_WIDTH-1:0] data;
  } res_t;

  state_t                      state;
  logic signed [ACC_WIDTH-1:0] acc;
  logic [CNT_W-1:0]            cnt;
  res_t                        res_q;
  res_t                        res_d;

  logic                        accept;
  logic signed [PROD_W-1:0]    prod;
  logic signed [ACC_WIDTH-1:0] sum_next;
  logic signed [RW-1:0]        sum_x;
  logic signed [RW-1:0]        r;

  assign busy      = (state != IDLE);
  assign pix_ready = (state == ACCUM);
  assign res_valid = (state == OUTPUT);
  assign accept    = pix_valid & pix_ready;
  // Rotate in the accept cycle so the next weight sits at the head on the next edge.
  assign shift_en  = accept;
  assign res_data  = res_q.data;
  assign res_sat   = res_q.sat;

  assign prod     = pix_data * weight_in;
  assign sum_next = acc + ACC_WIDTH'(prod);
  assign sum_x    = RW'(sum_next);

  // One guard bit so adding the half-LSB cannot wrap the final sum.
  generate
    if (OUT_SHIFT > 0) begin : g_round
      localparam logic signed [RW-1:0] HALF = RW'(2 ** (OUT_SHIFT - 1));
      assign r = (sum_x + HALF) >>> OUT_SHIFT;
    end else begin : g_noround
      assign r = sum_x;
    end
  endgenerate

  always_comb begin
    res_d.data = r[OUT_WIDTH-1:0];
    res_d.sat  = 1'b0;
    if (r > R_MAX) begin
      res_d.data = R_MAX[OUT_WIDTH-1:0];
      res_d.sat  = 1'b1;
    end else if (r < R_MIN) begin
      res_d.data = R_MIN[OUT_WIDTH-1:0];
      res_d.sat  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      res_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= ACCUM;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc <= sum_next;
            if (cnt == CNT_LAST) begin
              state <= OUTPUT;
              cnt   <= '0;
              res_q <= res_d;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        OUTPUT: begin
          if (res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_mac_engine.sv
// Directed bench for conv_mac_engine with a behavioural 9-entry rotating weight shifter.
module tb_conv_mac_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic pix_valid = 1'b0;
  logic res_ready = 1'b0;
  logic signed [7:0] pix_data = '0;
  logic signed [7:0] weight_in;
  logic busy, pix_ready, shift_en, res_valid, res_sat;
  logic signed [7:0] res_data;

  int checks = 0;
  int errors = 0;
  int shift_cnt = 0;

  logic signed [7:0] shreg  [9];
  logic signed [7:0] load_w [9];
  logic signed [7:0] px     [9];
  logic load_req = 1'b0;

  conv_mac_engine #(
    .DATA_WIDTH(8), .KERNEL_SIZE(9), .ACC_WIDTH(20), .OUT_WIDTH(8), .OUT_SHIFT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .weight_in(weight_in), .shift_en(shift_en),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_sat(res_sat)
  );

  always #5 clk = ~clk;

  assign weight_in = shreg[0];

  always @(posedge clk) begin
    if (shift_en) shift_cnt <= shift_cnt + 1;
    if (load_req) begin
      for (int i = 0; i < 9; i++) shreg[i] <= load_w[i];
    end else if (shift_en) begin
      for (int i = 0; i < 9; i++) shreg[i] <= shreg[(i + 1) % 9];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_weights();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  task automatic set_ramp_weights();
    for (int i = 0; i < 9; i++) load_w[i] = 8'(i + 1);
    load_weights();
  endtask

  // Runs one window with px[] and 'gap' idle cycles between pixels; leaves engine in OUTPUT.
  task automatic do_window(input string name, input int gap,
                           input logic signed [7:0] exp_data, input logic exp_sat);
    int n0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (pix_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s start: pix_ready=%b busy=%b want 1 1", name, pix_ready, busy);
    end
    n0 = shift_cnt;
    for (int k = 0; k < 9; k++) begin
      if (k > 0) begin
        for (int g = 0; g < gap; g++) begin
          pix_valid = 1'b0;
          #1;
          checks++;
          if (shift_en !== 1'b0) begin
            errors++;
            $display("FAIL %s gap shift_en: got %b want 0", name, shift_en);
          end
          tick();
        end
      end
      pix_valid = 1'b1;
      pix_data  = px[k];
      #1;
      checks++;
      if (shift_en !== 1'b1 || res_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s accept %0d: shift_en=%b res_valid=%b want 1 0", name, k, shift_en, res_valid);
      end
      tick();
    end
    pix_valid = 1'b0;
    checks++;
    if (res_valid !== 1'b1 || pix_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s latency: res_valid=%b pix_ready=%b want 1 0", name, res_valid, pix_ready);
    end
    checks++;
    if (res_data !== exp_data || res_sat !== exp_sat) begin
      errors++;
      $display("FAIL %s result: got %0d sat %b want %0d sat %b", name, res_data, res_sat, exp_data, exp_sat);
    end
    checks++;
    if (shift_cnt - n0 != 9) begin
      errors++;
      $display("FAIL %s shift count: got %0d want 9", name, shift_cnt - n0);
    end
    checks++;
    if (weight_in !== load_w[0]) begin
      errors++;
      $display("FAIL %s head weight: got %0d want %0d", name, weight_in, load_w[0]);
    end
  endtask

  task automatic accept_result(input string name);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s drain: res_valid=%b busy=%b want 0 0", name, res_valid, busy);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({busy, pix_ready, shift_en, res_valid, res_sat} !== 5'b0 || res_data !== 8'sd0) begin
      errors++;
      $display("FAIL %s: busy=%b pix_ready=%b shift_en=%b res_valid=%b res_data=%0d res_sat=%b want all 0",
               name, busy, pix_ready, shift_en, res_valid, res_data, res_sat);
    end
  endtask

  task automatic test_reset();
    #3;
    check_all_zero("reset");
    tick();
    rst_n = 1'b1;
    tick();
    check_all_zero("post_reset_idle");
  endtask

  task automatic test_basic();
    set_ramp_weights();
    for (int i = 0; i < 9; i++) px[i] = 8'sd1;
    do_window("basic", 0, 8'sd3, 1'b0);
    accept_result("basic");
  endtask

  task automatic test_back_to_back();
    set_ramp_weights();
    for (int i = 0; i < 9; i++) px[i] = 8'(i + 1);
    do_window("b2b_first", 0, 8'sd18, 1'b0);
    accept_result("b2b_first");
    do_window("b2b_second", 0, 8'sd18, 1'b0);
    accept_result("b2b_second");
  endtask

  task automatic test_neg_round();
    set_ramp_weights();
    for (int i = 0; i < 9; i++) px[i] = -8'sd1;
    do_window("neg_round", 0, -8'sd3, 1'b0);
    accept_result("neg_round");
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 9; i++) load_w[i] = 8'sd127;
    load_weights();
    for (int i = 0; i < 9; i++) px[i] = 8'sd127;
    do_window("sat_pos", 0, 8'sd127, 1'b1);
    accept_result("sat_pos");
    for (int i = 0; i < 9; i++) px[i] = -8'sd128;
    do_window("sat_neg", 0, -8'sd128, 1'b1);
    accept_result("sat_neg");
  endtask

  task automatic test_boundaries();
    for (int i = 0; i < 9; i++) load_w[i] = 8'sd2;
    load_weights();
    for (int i = 0; i < 8; i++) px[i] = 8'sd112;
    px[8] = 8'sd116;
    do_window("edge_max", 0, 8'sd127, 1'b0);
    accept_result("edge_max");
    px[8] = 8'sd124;
    do_window("edge_max_over", 0, 8'sd127, 1'b1);
    accept_result("edge_max_over");
    for (int i = 0; i < 8; i++) px[i] = -8'sd114;
    px[8] = -8'sd116;
    do_window("edge_min", 0, -8'sd128, 1'b0);
    accept_result("edge_min");
    px[8] = -8'sd117;
    do_window("edge_min_over", 0, -8'sd128, 1'b1);
    accept_result("edge_min_over");
  endtask

  task automatic test_gaps();
    set_ramp_weights();
    for (int i = 0; i < 9; i++) px[i] = 8'sd1;
    do_window("gaps", 2, 8'sd3, 1'b0);
    accept_result("gaps");
  endtask

  task automatic test_output_hold();
    set_ramp_weights();
    for (int i = 0; i < 9; i++) px[i] = 8'(i + 1);
    do_window("hold", 0, 8'sd18, 1'b0);
    for (int c = 0; c < 5; c++) begin
      start     = (c == 2);
      pix_valid = (c >= 2);
      #1;
      checks++;
      if (res_valid !== 1'b1 || res_data !== 8'sd18 || res_sat !== 1'b0 ||
          pix_ready !== 1'b0 || shift_en !== 1'b0) begin
        errors++;
        $display("FAIL hold cycle %0d: res_valid=%b res_data=%0d res_sat=%b pix_ready=%b shift_en=%b want 1 18 0 0 0",
                 c, res_valid, res_data, res_sat, pix_ready, shift_en);
      end
      tick();
    end
    start     = 1'b0;
    pix_valid = 1'b0;
    accept_result("hold");
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL hold start_ignored: busy got %b want 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    set_ramp_weights();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      pix_valid = 1'b1;
      pix_data  = 8'sd100;
      tick();
    end
    pix_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_mid");
    tick();
    rst_n = 1'b1;
    tick();
    set_ramp_weights();
    for (int i = 0; i < 9; i++) px[i] = 8'sd1;
    do_window("after_reset", 0, 8'sd3, 1'b0);
    accept_result("after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_neg_round();
    test_saturation();
    test_boundaries();
    test_gaps();
    test_output_hold();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_mac_engine.md
Name: conv_mac_engine

Overview:
Downstream consumer of the 9-entry rotating weight shifter in the convolution datapath. It takes the head weight (`weight_in`) and multiplies it with one incoming pixel per accepted handshake. It pulses `shift_en` to advance the shifter and accumulates KERNEL_SIZE signed products. It then emits one rounded, saturated output sample over a valid/ready interface. After one complete window the shifter has rotated exactly KERNEL_SIZE times, so the weights are realigned for the next window.

Parameters:
- DATA_WIDTH, 8: width of pixel and weight, both signed two's complement
- KERNEL_SIZE, 9: products per window; must equal the shifter depth
- ACC_WIDTH, 20: signed accumulator width; must be at least 2*DATA_WIDTH+ceil(log2(KERNEL_SIZE))
- OUT_WIDTH, 8: signed result width
- OUT_SHIFT, 4: arithmetic right shift applied to the accumulator before saturation; 0 means no shift and no rounding

Ports:
- clk, input, 1: clock
- rst_n, input, 1: asynchronous active-low reset
- start, input, 1: begin a new window; honoured only in IDLE
- busy, output, 1: high whenever the state is not IDLE
- pix_valid, input, 1: pixel available
- pix_ready, output, 1: engine can accept a pixel
- pix_data, input, DATA_WIDTH: signed pixel
- weight_in, input, DATA_WIDTH: signed weight, driven by the shifter head
- shift_en, output, 1: rotate the shifter by one position
- res_valid, output, 1: result available
- res_ready, input, 1: downstream accepts the result
- res_data, output, OUT_WIDTH: signed result
- res_sat, output, 1: res_data was clipped

Behaviour:
- Reset (asynchronous, active-low; clock clk):
  - state=IDLE, acc=0, cnt=0.
  - busy=0, pix_ready=0, shift_en=0, res_valid=0, res_data=0, res_sat=0.
  - Reset mid-window discards the partial sum. Shifter alignment is the system's responsibility; the shifter resets with the same rst_n.
- FSM states: IDLE, ACCUM, OUTPUT.
- IDLE:
  - pix_ready=0.
  - start=1 -> ACCUM next cycle; acc and cnt cleared.
- ACCUM:
  - pix_ready=1 (combinational in ACCUM).
  - Accept happens when pix_valid & pix_ready. On an accept:
    - acc <= acc + sext(pix_data)*sext(weight_in), with full-width signed multiply sign-extended to ACC_WIDTH.
    - cnt <= cnt+1.
    - shift_en=1 in the same cycle (combinational), so the next weight is at the head on the following cycle.
  - No accept -> acc, cnt unchanged; shift_en=0.
  - Accept with cnt==KERNEL_SIZE-1 -> OUTPUT next cycle. The final sum (acc plus this product) is rounded/saturated and registered into res_data/res_sat in the same edge; cnt -> 0.
- OUTPUT:
  - res_valid=1; res_data and res_sat held stable; pix_ready=0; shift_en=0.
  - res_ready=1 -> IDLE next cycle, res_valid drops.
  - res_valid may be asserted without waiting for res_ready.
- Rounding and saturation:
  - OUT_SHIFT>0: r = (sum + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT, computed in ACC_WIDTH+1 bits.
  - OUT_SHIFT=0: r = sum.
  - r > 2^(OUT_WIDTH-1)-1 -> res_data = max, res_sat=1.
  - r < -2^(OUT_WIDTH-1) -> res_data = min, res_sat=1.
  - Otherwise res_data = r, res_sat=0.
- Latency and throughput:
  - Last pixel accepted at edge N -> res_valid high from cycle N+1.
  - Minimum window is 1 (start) + 9 (pixels) + 1 (output) = 11 cycles.
- start while busy: ignored.
- shift_en is asserted exactly KERNEL_SIZE times per window, never in IDLE or OUTPUT.

Test Plan:
1. Weights 1..9 loaded into the shifter, start, nine pixels of value 1 back-to-back -> shift_en high on 9 consecutive cycles, acc=45, res_data=(45+8)>>>4=3, res_sat=0. res_valid appears 1 cycle after the 9th accept, and the shifter head returns to weight 1.
2. All weights and pixels = 127 -> sum=145161, r=9073 -> res_data=127, res_sat=1.
3. Pixels -128, weights 127 -> sum=-146304, r=-9144 -> res_data=-128, res_sat=1.
4. pix_valid toggling 1,0,0,1,... with gaps -> exactly 9 accepts, shift_en only on accept cycles, same result as the gap-free run.
5. res_ready held low 5 cycles in OUTPUT -> res_valid, res_data, res_sat stable; pix_ready=0; shift_en=0; a start pulse is ignored; IDLE entered one cycle after res_ready=1.
6. Assert rst_n low after 4 accepts -> all outputs 0 immediately (asynchronous). A subsequent start plus 9 pixels gives a result with no contribution from the aborted window.
